mem_bus_arbiter: RTL and testbench

- Shares the single synchronous program/data RAM between two requesters: port C (the 6502 core's fetch/operand bus) and port X (auxiliary master, e.g. program loader or DMA).
- Port C has fixed priority. A starvation counter and an X-side lock override that priority.
- Sits between cpu_core, the auxiliary master and the block RAM. It registers every RAM command and routes read data back to the requester that issued it.

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/rd_return_pipe.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared encodings and default widths for the RAM arbiter and its read-return pipe.
package cpu_bus_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 8;
  localparam int MAX_WAIT_DEF   = 4;
  localparam int RD_LATENCY_DEF = 1;
  localparam int WAIT_CNT_W     = 4;

  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_X = 1'b1;

  typedef enum logic {
    ST_NORM = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Tracks in-flight reads by owner tag and steers returning RAM data to the issuing port.
module rd_return_pipe
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              push_tag,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata
);

  logic [RD_LATENCY:0] vld_pipe;
  logic [RD_LATENCY:0] tag_pipe;
  logic                ret_c;
  logic                ret_x;

  // The last stage lines up with the cycle mem_rdata holds the answer.
  assign ret_c = vld_pipe[RD_LATENCY] & (tag_pipe[RD_LATENCY] == OWNER_C);
  assign ret_x = vld_pipe[RD_LATENCY] & (tag_pipe[RD_LATENCY] == OWNER_X);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LATENCY-1:0], push};
      tag_pipe <= {tag_pipe[RD_LATENCY-1:0], push_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_rvalid <= 1'b0;
      x_rvalid <= 1'b0;
      c_rdata  <= '0;
      x_rdata  <= '0;
    end else begin
      c_rvalid <= ret_c;
      x_rvalid <= ret_x;
      if (ret_c) c_rdata <= mem_rdata;
      if (ret_x) x_rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared program/data RAM: C has priority, X gets starvation
// relief and can lock the bus for bursts. Commands are registered, read data routed back.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  input  logic              x_lock,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner_lock
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(MAX_WAIT);

  arb_state_e              state, state_nxt;
  logic [WAIT_CNT_W-1:0]   wait_cnt, wait_nxt;
  logic                    starved;
  logic                    c_fire;
  logic                    x_fire;
  logic                    rd_push;

  assign starved = (wait_cnt >= WAIT_LIM);
  assign c_fire  = c_req & c_gnt;
  assign x_fire  = x_req & x_gnt;

  always_comb begin
    c_gnt     = 1'b0;
    x_gnt     = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!reset) begin
      case (state)
        ST_NORM: begin
          x_gnt = x_req & (~c_req | starved);
          c_gnt = c_req & ~x_gnt;
        end
        ST_LOCK: begin
          x_gnt = x_req;
        end
        default: ;
      endcase
    end

    case (state)
      ST_NORM: if (x_fire && x_lock) state_nxt = ST_LOCK;
      ST_LOCK: if ((x_fire && !x_lock) || !x_req) state_nxt = ST_NORM;
      default: state_nxt = ST_NORM;
    endcase

    if (x_fire || !x_req) wait_nxt = '0;
    else if (!x_gnt)      wait_nxt = sat_inc(wait_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_NORM;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign owner_lock = (state == ST_LOCK);

  // Non-transfer cycles drop the strobe but keep the last command fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= c_fire | x_fire;
      if (x_fire) begin
        mem_we    <= x_we;
        mem_addr  <= x_addr;
        mem_wdata <= x_wdata;
      end else if (c_fire) begin
        mem_we    <= c_we;
        mem_addr  <= c_addr;
        mem_wdata <= c_wdata;
      end
    end
  end

  assign rd_push = (c_fire & ~c_we) | (x_fire & ~x_we);

  rd_return_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_ret (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_push),
    .push_tag  (x_fire ? OWNER_X : OWNER_C),
    .mem_rdata (mem_rdata),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .x_rvalid  (x_rvalid),
    .x_rdata   (x_rdata)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: reference model predicts grants, RAM commands and
// read returns; a negedge monitor compares everything the DUT presents.
module tb_mem_bus_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int MW  = 4;
  localparam int RDL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          x_req, x_we, x_lock, x_gnt, x_rvalid;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rdata;
  logic          mem_en, mem_we, owner_lock;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_lock(x_lock),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner_lock(owner_lock)
  );

  // Synchronous RAM with RDL clocks from sampled command to data
  logic [DW-1:0] ram     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] rpipe   [0:RDL-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rpipe[0] <= ram[mem_addr];
    for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RDL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { bit port; logic [DW-1:0] data; int due; } rd_t;
  rd_t           q[$];
  int            cyc = 0;
  bit            m_lock = 0;
  int            m_wait = 0;
  bit            ec = 0, ex = 0;
  bit            e_en = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [DW-1:0] exp_crd = '0, exp_xrd = '0;
  int            n_rv = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_lock = 0; m_wait = 0; q.delete();
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      exp_crd = '0; exp_xrd = '0;
    end else begin
      if (ex || ec) begin
        e_en    = 1;
        e_we    = ex ? x_we    : c_we;
        e_addr  = ex ? x_addr  : c_addr;
        e_wdata = ex ? x_wdata : c_wdata;
        if (e_we) ref_mem[e_addr] = e_wdata;
        else      q.push_back('{ex, ref_mem[e_addr], cyc + RDL + 1});
      end else begin
        e_en = 0;
      end
      if (!m_lock) begin
        if (ex && x_lock) m_lock = 1;
      end else if ((ex && !x_lock) || !x_req) begin
        m_lock = 0;
      end
      if (ex || !x_req) m_wait = 0;
      else if (m_wait < 15) m_wait++;
    end
  end

  // Monitor: grants for this cycle, command from the last edge, read returns
  always @(negedge clk) begin
    rd_t r;
    if (reset)       begin ec = 0; ex = 0; end
    else if (m_lock) begin ec = 0; ex = x_req; end
    else begin
      ex = x_req && (!c_req || m_wait >= MW);
      ec = c_req && !ex;
    end
    chk("grants", {c_gnt, x_gnt}, {ec, ex});
    chk("owner_lock", owner_lock, m_lock);
    chk("mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {e_en, e_we, e_addr, e_wdata});
    if (c_rvalid && x_rvalid) chk("rvalid_onehot", 2'b11, 2'b00);
    if (c_rvalid || x_rvalid) begin
      n_rv++;
      if (q.size() == 0) begin
        chk("spurious_rvalid", {c_rvalid, x_rvalid}, 2'b00);
      end else begin
        r = q.pop_front();
        chk("rd_port", x_rvalid, r.port);
        chk("rd_time", cyc, r.due);
        chk("rd_data", x_rvalid ? x_rdata : c_rdata, r.data);
        if (r.port) exp_xrd = r.data; else exp_crd = r.data;
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      chk("missing_rvalid", 1'b0, 1'b1);
    end
    chk("c_rdata_hold", c_rdata, exp_crd);
    chk("x_rdata_hold", x_rdata, exp_xrd);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input bit is_x);
    int n = 0;
    bit g;
    do begin
      @(negedge clk);
      g = is_x ? x_gnt : c_gnt;
      @(posedge clk); #1;
      n++;
    end while (!g && n < 50);
    chk(is_x ? "x_gnt_timeout" : "c_gnt_timeout", g, 1'b1);
  endtask

  task automatic c_set(input bit we, input int a, input int d);
    c_req = 1; c_we = we; c_addr = AW'(a); c_wdata = DW'(d);
  endtask

  task automatic x_set(input bit we, input int a, input int d, input bit lk);
    x_req = 1; x_we = we; x_addr = AW'(a); x_wdata = DW'(d); x_lock = lk;
  endtask

  initial begin
    int nc, rv0;
    bit cf, xf;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = DW'(i * 37 + 11);
      ref_mem[i] = DW'(i * 37 + 11);
    end
    ram[16'h0010] = 8'hA9; ref_mem[16'h0010] = 8'hA9;
    ram[16'h0001] = 8'h5A; ref_mem[16'h0001] = 8'h5A;
    ram[16'h0002] = 8'hC3; ref_mem[16'h0002] = 8'hC3;
    reset = 1; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_lock = 0;
    repeat (3) step();
    reset = 0;

    // C read after reset
    c_set(0, 16'h0010, 0);
    #1 chk("c_gnt_same_cycle", c_gnt, 1'b1);
    wait_gnt(0);
    c_req = 0;
    #1 chk("first_cmd", {mem_en, mem_addr}, {1'b1, 16'h0010});
    repeat (5) step();

    // Starvation relief
    c_set(0, 16'h0001, 0);
    x_set(0, 16'h0002, 0, 0);
    nc = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (x_gnt) break;
      if (c_gnt) nc++;
      step();
    end
    chk("starve_c_grants", nc, MW);
    step();
    #1 chk("c_after_x", {c_gnt, x_gnt}, 2'b10);
    x_req = 0; c_req = 0;
    repeat (5) step();

    // Locked write burst against a busy C
    c_set(0, 16'h0001, 0);
    x_set(1, 16'h0200, 8'h11, 1);
    wait_gnt(1);
    x_set(1, 16'h0201, 8'h22, 1);
    #1 chk("lock_burst2", {owner_lock, c_gnt, x_gnt}, 3'b101);
    wait_gnt(1);
    x_set(1, 16'h0202, 8'h33, 0);
    #1 chk("lock_burst3", {owner_lock, c_gnt, x_gnt}, 3'b101);
    wait_gnt(1);
    x_req = 0;
    #1 chk("lock_release", {owner_lock, c_gnt}, 2'b01);
    c_set(0, 16'h0202, 0);
    wait_gnt(0);
    c_req = 0;
    repeat (5) step();
    chk("burst_mem", {ram[16'h0200], ram[16'h0201], ram[16'h0202]}, 24'h112233);

    // Lock abandoned by dropping x_req
    c_set(0, 16'h0001, 0);
    x_set(0, 16'h0002, 0, 1);
    wait_gnt(1);
    x_req = 0;
    step();
    #1 chk("abandon", {owner_lock, c_gnt}, 2'b01);
    c_req = 0;
    repeat (5) step();

    // Back-to-back interleave
    rv0 = n_rv;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin x_req = 0; c_set(0, 16'h0001, 0); end
      else begin c_req = 0; x_set(0, 16'h0002, 0, 0); end
      step();
    end
    c_req = 0; x_req = 0;
    repeat (6) step();
    chk("interleave_count", n_rv - rv0, 8);

    // Reset while a read is in flight
    c_set(0, 16'h0010, 0);
    wait_gnt(0);
    c_req = 0;
    reset = 1;
    step();
    #1 chk("reset_outs", {c_gnt, x_gnt, mem_en, mem_we, mem_addr, mem_wdata, c_rvalid, x_rvalid,
                         c_rdata, x_rdata, owner_lock}, '0);
    reset = 0;
    rv0 = n_rv;
    repeat (6) step();
    chk("no_rvalid_after_reset", n_rv - rv0, 0);
    c_set(0, 16'h0010, 0);
    wait_gnt(0);
    c_req = 0;
    repeat (5) step();

    // Randomized traffic with occasional resets
    cf = 0; xf = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_req || cf) begin
        c_req = ($urandom_range(0, 99) < 60); c_we = $urandom_range(0, 1);
        c_addr = AW'($urandom_range(0, 15)); c_wdata = DW'($urandom);
      end
      if (!x_req || xf) begin
        x_req = ($urandom_range(0, 99) < 40); x_we = $urandom_range(0, 1);
        x_addr = AW'($urandom_range(0, 15)); x_wdata = DW'($urandom);
        x_lock = ($urandom_range(0, 99) < 25);
      end
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      cf = c_req & c_gnt;
      xf = x_req & x_gnt;
      @(posedge clk); #1;
    end
    c_req = 0; x_req = 0; reset = 0;
    repeat (10) step();
    chk("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
